// File: rtl/vip_pkg.sv
// Shared video-pipeline definitions for the binary morphology stages.
// Holds the default image geometry, the erosion sync latency and the sync
// bundle carried alongside pixel data (also used by the dilation stage).
package vip_pkg;

    localparam int unsigned IMG_HDISP_DEFAULT = 640;
    localparam int unsigned IMG_VDISP_DEFAULT = 480;
    localparam int unsigned EROSION_LATENCY   = 3;

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_bundle_t;

endpackage

// File: rtl/bit_line_buffer.sv
// One-bit-wide line buffer, DEPTH entries, synchronous write and registered
// read. A read and a write to the same address in one cycle return the old
// contents.
// Ports:
//   clk, rst_n        clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data  write port
//   rd_addr           read address, sampled every cycle
//   rd_data           registered read data
module bit_line_buffer #(
    parameter int unsigned DEPTH = 640,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_data
);

    logic mem [DEPTH];

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 1'b0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bit_erosion_3x3.sv
// Streaming 3x3 binary erosion. The output for input pixel (r,c) is the AND of
// rows r-2..r, cols c-2..c, i.e. the erosion centred at (r-1,c-1). Latency is
// three clocks for both the pixel and the sync signals.
// Configuration macro: EROSION_BORDER_ZERO_EN -- when defined, any window that
// touches an out-of-frame position yields 0; otherwise out-of-frame positions
// read as 1.
// Ports:
//   clk, rst_n                        pixel clock, async active-low reset
//   per_frame_vsync/href/clken        input syncs
//   per_img_Bit                       input binary pixel
//   post_frame_vsync/href/clken       input syncs delayed by 3 clocks
//   post_img_Bit                      eroded pixel, 0 when not a valid strobe
module bit_erosion_3x3
    import vip_pkg::*;
#(
    parameter int unsigned IMG_HDISP = IMG_HDISP_DEFAULT,
    parameter int unsigned IMG_VDISP = IMG_VDISP_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic per_frame_vsync,
    input  logic per_frame_href,
    input  logic per_frame_clken,
    input  logic per_img_Bit,
    output logic post_frame_vsync,
    output logic post_frame_href,
    output logic post_frame_clken,
    output logic post_img_Bit
);

    localparam int unsigned COL_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int unsigned ROW_W = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_HDISP - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_VDISP - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             href_prev;
    logic             vsync_prev;
    logic             line_active;

    logic line_on_c;
    logic pix_c;
    logic href_fall_c;
    logic vsync_rise_c;

    // A line only counts once its href rising edge has been seen, so a line
    // cut by reset is ignored and the next line restarts at row 0.
    assign line_on_c    = per_frame_href & (line_active | ~href_prev);
    assign pix_c        = line_on_c & per_frame_clken;
    assign href_fall_c  = href_prev & ~per_frame_href;
    assign vsync_rise_c = per_frame_vsync & ~vsync_prev;

    // Edge detectors; href_prev resets high so a line in progress at reset
    // release does not look like a fresh line start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_prev   <= 1'b1;
            vsync_prev  <= 1'b0;
            line_active <= 1'b0;
        end else begin
            href_prev   <= per_frame_href;
            vsync_prev  <= per_frame_vsync;
            line_active <= line_on_c;
        end
    end

    // Saturating column and row counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else begin
            if (!per_frame_href) begin
                col <= '0;
            end else if (pix_c && (col != COL_MAX)) begin
                col <= col + COL_W'(1);
            end

            if (vsync_rise_c) begin
                row <= '0;
            end else if (href_fall_c && line_active && (row != ROW_MAX)) begin
                row <= row + ROW_W'(1);
            end
        end
    end

    // S1: line buffer reads plus capture of pixel and position flags.
    logic             lb1_rd;
    logic             lb2_rd;
    logic             s1_valid;
    logic             s1_pix;
    logic [COL_W-1:0] s1_col;
    logic             s1_row0;
    logic             s1_row01;
    logic             s1_col0;
    logic             s1_col01;

    // LB1 holds row r-1; LB2 receives LB1's old value one cycle later.
    bit_line_buffer #(.DEPTH(IMG_HDISP)) u_lb1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (pix_c),
        .wr_addr (col),
        .wr_data (per_img_Bit),
        .rd_addr (col),
        .rd_data (lb1_rd)
    );

    bit_line_buffer #(.DEPTH(IMG_HDISP)) u_lb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (s1_valid),
        .wr_addr (s1_col),
        .wr_data (lb1_rd),
        .rd_addr (col),
        .rd_data (lb2_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pix   <= 1'b0;
            s1_col   <= '0;
            s1_row0  <= 1'b0;
            s1_row01 <= 1'b0;
            s1_col0  <= 1'b0;
            s1_col01 <= 1'b0;
        end else begin
            s1_valid <= pix_c;
            s1_pix   <= per_img_Bit;
            s1_col   <= col;
            s1_row0  <= (row == '0);
            s1_row01 <= (row <= ROW_W'(1));
            s1_col0  <= (col == '0);
            s1_col01 <= (col <= COL_W'(1));
        end
    end

    // S2: window shift with out-of-frame rows forced to 1 before entry.
    logic [2:0] win_top;
    logic [2:0] win_mid;
    logic [2:0] win_bot;
    logic       s2_valid;
    logic       s2_colm1;
    logic       s2_colm2;
    logic       s2_border;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_top   <= '0;
            win_mid   <= '0;
            win_bot   <= '0;
            s2_valid  <= 1'b0;
            s2_colm1  <= 1'b0;
            s2_colm2  <= 1'b0;
            s2_border <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                win_top   <= {win_top[1:0], lb2_rd | s1_row01};
                win_mid   <= {win_mid[1:0], lb1_rd | s1_row0};
                win_bot   <= {win_bot[1:0], s1_pix};
                s2_colm1  <= s1_col0;
                s2_colm2  <= s1_col01;
                s2_border <= s1_row01 | s1_col01;
            end
        end
    end

    // S3: AND reduction; bit 0 is col c, bit 1 is c-1, bit 2 is c-2.
    logic [2:0] col_and_c;
    logic       erode_c;

    assign col_and_c = win_top & win_mid & win_bot;

`ifdef EROSION_BORDER_ZERO_EN
    assign erode_c = ~s2_border & (&col_and_c);
`else
    assign erode_c = col_and_c[0] & (col_and_c[1] | s2_colm1) & (col_and_c[2] | s2_colm2);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_img_Bit <= 1'b0;
        end else begin
            post_img_Bit <= s2_valid & erode_c;
        end
    end

    // Fixed sync delay line aligned with the three data stages.
    sync_bundle_t sync_dly [EROSION_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < EROSION_LATENCY; i++) begin
                sync_dly[i] <= '0;
            end
        end else begin
            sync_dly[0] <= '{vsync: per_frame_vsync, href: per_frame_href, clken: per_frame_clken};
            for (int unsigned i = 1; i < EROSION_LATENCY; i++) begin
                sync_dly[i] <= sync_dly[i-1];
            end
        end
    end

    assign post_frame_vsync = sync_dly[EROSION_LATENCY-1].vsync;
    assign post_frame_href  = sync_dly[EROSION_LATENCY-1].href;
    assign post_frame_clken = sync_dly[EROSION_LATENCY-1].clken;

    // s2_border is only consumed when border zeroing is built in.
    logic unused_c;
    assign unused_c = s2_border;

endmodule

// File: doc/bit_erosion_3x3.md
# bit_erosion_3x3

Streaming 3x3 morphological erosion on a 1-bit image. Sits directly downstream of the binarization stage and consumes its `post_frame_vsync`, `post_frame_href`, `post_frame_clken` and `post_img_Bit` outputs. It produces a same-format, same-size eroded bit stream for the Sobel stage. Internally it holds two line buffers, a 3x3 window, row/column counters and a fixed 3-cycle sync delay line.

## Interface
- `IMG_HDISP`, default 640: maximum active pixels per line; sets line-buffer depth.
- `IMG_VDISP`, default 480: maximum lines per frame; sets row-counter width.
- `clk` in, 1 bit: pixel clock. One clock; all logic on its rising edge.
- `rst_n` in, 1 bit: reset, asynchronous and active-low.
- `per_frame_vsync` in, 1 bit: frame sync; high during the frame.
- `per_frame_href` in, 1 bit: line valid.
- `per_frame_clken` in, 1 bit: pixel strobe; only meaningful while href=1.
- `per_img_Bit` in, 1 bit: binary pixel; 1 = foreground.
- `post_frame_vsync` out, 1 bit: vsync delayed 3 cycles.
- `post_frame_href` out, 1 bit: href delayed 3 cycles.
- `post_frame_clken` out, 1 bit: clken delayed 3 cycles.
- `post_img_Bit` out, 1 bit: eroded pixel; 0 whenever `post_frame_clken`=0.

## Operation
- **Column counter `col`**
  - Increments on each input pixel (href & clken).
  - Clears when href falls.
  - Saturates at IMG_HDISP-1; extra pixels overwrite the last buffer address.
- **Row counter `row`**
  - Increments on each href falling edge.
  - Clears on vsync rising edge.
  - Saturates at IMG_VDISP-1.
- **Line buffers LB1/LB2**
  - Each is IMG_HDISP x 1 bit, addressed by `col`.
  - On each input pixel: LB2[col] <= LB1[col]; LB1[col] <= per_img_Bit.
  - LB1 holds row-1; LB2 holds row-2.
  - Read is registered, same address.
- **Window**
  - Three 3-bit shift registers: rows r-2, r-1, r.
  - Shift only on pixel strobes.
- **Output mapping**
  - The output for input pixel (r,c) is the AND of pixels rows r-2..r, cols c-2..c. This is the erosion centered at (r-1,c-1).
  - Output pixel count and line structure equal the input.
- **Out-of-frame handling**
  - Window positions with row<0 or col<0 are out-of-frame, determined from the counters only.
  - Stale buffer content from a previous frame must never affect row 0/1 results.
  - Default behaviour: out-of-frame positions read as 1.
- **Mid-line vsync/href glitch:** no special handling; the counters follow the rules above.

## Timing
- Latency: exactly 3 clk from input pixel to its `post_img_Bit`. `post_*` syncs are the `per_*` syncs delayed 3 clk.
- Pipeline stages:
  - S1: LB read and input capture.
  - S2: window shift and mask computation.
  - S3: AND and output register.
- Idle cycles (clken=0) inside href: the window does not shift. Output pairing is preserved because the S1-S3 data stages advance every cycle alongside their delayed clken.
- Reset: all outputs 0, counters 0, window 0, delay line 0. LB contents are don't-care because of counter masking.
- Reset mid-frame: output is 0 until restart. The next line is treated as row 0 without needing a vsync edge.
- Back-to-back frames (vsync low for ≥1 cycle): the row counter restarts correctly.

## Configuration
- `EROSION_BORDER_ZERO_EN` defined: any window containing an out-of-frame position outputs 0. Row 0/1 and col 0/1 outputs are all 0.
- Undefined: out-of-frame positions treated as 1. The border is eroded only by in-frame zeros.

## Structure
- Shared package `vip_pkg` holds:
  - `IMG_HDISP`/`IMG_VDISP` defaults.
  - Sync delay constant `EROSION_LATENCY = 3`.
  - A sync-bundle struct {vsync, href, clken}, reused by the dilation stage.
- One natural sub-module: `bit_line_buffer`, a parameterized IMG_HDISP x 1 RAM with registered read, instantiated twice. A later dilation block reuses it.

## Test plan
- 8x6 frame all 1s:
  - Without macro: all outputs 1.
  - With macro: rows 0-1 and cols 0-1 are 0, the rest 1.
- 8x6 all 1s except a single 0 at (3,4): outputs 0 exactly at input positions (3..5, 4..6), i.e. centers (2..4, 3..5); all others 1 (without macro).
- Random 16x12 frame with random clken gaps (30% idle) inside href: the bit-exact match to the golden model holds, and `post_*` equals `per_*` delayed 3 clk on every cycle.
- Two consecutive frames, first all 0s then all 1s, without macro: second frame is all 1s, showing stale LB content is masked.
- Assert `rst_n`=0 mid-line 3 for 2 cycles: all outputs 0 within the same cycle. The next line output equals row-0 behaviour.
- Line of 700 pixels with IMG_HDISP=640: no X, `col` saturates, and sync delay is still exactly 3.
